fruit_template_sad: RTL and testbench
=====================================

# fruit_template_sad

Read-side engine for the fruit template ROMs (2048 x 8, HEX-initialised, one per fruit class). On `start` it walks the ROM address space, pairs each template byte with one sample of a captured feature vector delivered over a valid/ready stream, and accumulates the sum of absolute differences (SAD). Recognition logic downstream compares SAD values across fruit classes. It sits between the ISP feature extractor and a template ROM instance.

## Interface
- `ADDR_WIDTH`, 11: ROM address width.
- `DATA_WIDTH`, 8: ROM and feature sample width.
- `LENGTH`, 2048: entries compared per scan. Legal range is 1 to 2**ADDR_WIDTH.
- `RD_LATENCY`, 1: ROM read latency in cycles. 1 means no output register; 2 means output register enabled. No other values are legal.
- `SAD_WIDTH`, ADDR_WIDTH+DATA_WIDTH: accumulator and result width.

Ports:
- `clk`, in, 1: single clock. The ROM shares this clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begins a scan when sampled in IDLE.
- `abort`, in, 1: cancels a scan in progress.
- `busy`, out, 1: high while a scan is active.
- `rom_addr`, out, ADDR_WIDTH: registered ROM address.
- `rom_rd_data`, in, DATA_WIDTH: ROM read data.
- `feat_valid`, in, 1: feature sample valid.
- `feat_data`, in, DATA_WIDTH: feature sample.
- `feat_ready`, out, 1: block will accept a feature sample this cycle.
- `sad`, out, SAD_WIDTH: last completed SAD. Held between scans.
- `done`, out, 1: one-cycle pulse when `sad` is updated.

## Operation
- States: IDLE, WAIT, CMP.
- IDLE → WAIT when `start`=1 and `abort`=0.
  - On that edge: `rom_addr`←0, accumulator←0, wait counter←RD_LATENCY, `busy`←1.
- WAIT:
  - `rom_addr` is held.
  - Counter decrements each cycle. After exactly RD_LATENCY cycles, go to CMP.
- CMP:
  - `feat_ready`=1, combinational from state, forced to 0 when `abort`=1.
  - `rom_rd_data` is stable because the address is held.
  - Stall indefinitely while `feat_valid`=0.
- Handshake (`feat_valid` & `feat_ready`):
  - diff = |feat_data − rom_rd_data|, computed unsigned at DATA_WIDTH+1 bits.
  - Accumulator += diff.
  - If `rom_addr`==LENGTH−1: `sad`←accumulator+diff, `done`←1 for one cycle, `busy`←0, state→IDLE, `rom_addr`←0.
  - Otherwise: `rom_addr`+1, counter←RD_LATENCY, state→WAIT.
- Overflow is impossible: LENGTH·(2^DATA_WIDTH−1) < 2^SAD_WIDTH. There is no saturation logic.
- `abort` in WAIT or CMP:
  - Next state IDLE, `busy`←0, `rom_addr`←0.
  - `sad` is unchanged and `done` is not pulsed.
  - `abort` takes priority over a simultaneous handshake; that sample is not consumed.
- `start` while `busy` is ignored. `start` together with `abort` in IDLE is ignored.
- `rst` takes priority over everything and returns the block to IDLE from any state.

## Timing
- Reset values: `busy`=0, `done`=0, `feat_ready`=0, `rom_addr`=0, `sad`=0, state IDLE, accumulator 0.
- `start` is sampled at edge E. `busy` is high from E. The ROM samples address 0 at E+1.
- First `feat_ready` appears in the cycle after edge E+RD_LATENCY.
- With `feat_valid` held high, sample i is handshaken at edge E+(i+1)·(RD_LATENCY+1).
- `done` and the new `sad` are visible after edge E+LENGTH·(RD_LATENCY+1). `busy` falls at that same edge.
- Each `feat_valid` stall cycle adds one cycle to the scan. `rom_addr` does not change during a stall.
- A new `start` is accepted in the cycle `done` is high.

## Test plan
- Reset check: assert `rst` mid-scan for 1 cycle → next cycle all outputs are at reset values; a subsequent scan completes correctly.
- ROM all 0xFF, features all 0xFF, `feat_valid`=1, RD_LATENCY=1 → `sad`=0; `done` after edge E+4096.
- ROM all 0xFF, features all 0x00 → `sad`=522240 (0x7F800); exactly one `done` pulse.
- ROM ramp (addr & 0xFF), features 0, random `feat_valid` gaps → `sad`=261120; `rom_addr` stable across every stall; exactly 2048 handshakes.
- `abort` asserted with `feat_valid` at sample 100 → no `done`, `busy`=0 next cycle, `sad` keeps its prior value; restarting reproduces the expected result.
- RD_LATENCY=2 with a registered-output ROM model → no `feat_ready` earlier than 2 cycles after an address change; `done` after E+3·LENGTH; `start` pulses during the scan are ignored.

Source files
------------

// File: rtl/fruit_template_sad_if.sv
// Bus bundle between the SAD engine, its template ROM and the feature stream.
interface fruit_template_sad_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_rd_data;
    logic                  feat_valid;
    logic [DATA_WIDTH-1:0] feat_data;
    logic                  feat_ready;

    // Engine side: drives the ROM address and the stream ready.
    modport master (
        output rom_addr,
        output feat_ready,
        input  rom_rd_data,
        input  feat_valid,
        input  feat_data
    );

    // ROM / feature source side.
    modport slave (
        input  rom_addr,
        input  feat_ready,
        output rom_rd_data,
        output feat_valid,
        output feat_data
    );
endinterface

// File: rtl/fruit_template_sad.sv
// Template ROM read engine: walks ROM addresses 0..LENGTH-1, pairs each byte
// with one streamed feature sample and accumulates the sum of absolute
// differences. The address is held while waiting for ROM data and stream data.
module fruit_template_sad #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 2048,
    parameter int RD_LATENCY = 1,
    parameter int SAD_WIDTH  = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic [SAD_WIDTH-1:0]  sad,
    output logic                  done,
    fruit_template_sad_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [1:0]            LAT       = 2'(RD_LATENCY);

    state_t                state;
    logic [1:0]            wait_cnt;
    logic [SAD_WIDTH-1:0]  acc;
    logic [DATA_WIDTH:0]   diff;
    logic [SAD_WIDTH-1:0]  acc_next;

    // Ready only in CMP; abort suppresses it so an aborted sample is not consumed.
    always_comb begin
        bus.feat_ready = (state == CMP) && !abort;
    end

    // Unsigned absolute difference, one bit wider than the samples.
    always_comb begin
        diff = '0;
        if (bus.feat_data >= bus.rom_rd_data)
            diff = {1'b0, bus.feat_data} - {1'b0, bus.rom_rd_data};
        else
            diff = {1'b0, bus.rom_rd_data} - {1'b0, bus.feat_data};
        acc_next = acc + SAD_WIDTH'(diff);
    end

    // Scan FSM with registered address, busy, done and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sad          <= '0;
            bus.rom_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state        <= WAIT;
                        bus.rom_addr <= '0;
                        acc          <= '0;
                        wait_cnt     <= LAT;
                        busy         <= 1'b1;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        bus.rom_addr <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                        if (wait_cnt == 2'd1)
                            state <= CMP;
                    end
                end
                CMP: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        bus.rom_addr <= '0;
                    end else if (bus.feat_valid) begin
                        acc <= acc_next;
                        if (bus.rom_addr == LAST_ADDR) begin
                            sad          <= acc_next;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
                            bus.rom_addr <= '0;
                        end else begin
                            bus.rom_addr <= bus.rom_addr + 1'b1;
                            wait_cnt     <= LAT;
                            state        <= WAIT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fruit_template_sad.sv
// Directed bench: a latency-1 engine over full 2048 entries and a latency-2
// engine over 64 entries, both fed from a bench-side template memory.
module tb_fruit_template_sad;

    localparam int LEN_A = 2048;
    localparam int LEN_B = 64;

    logic clk;
    logic rst;
    logic a_start, a_abort, a_busy, a_done;
    logic b_start, b_abort, b_busy, b_done;
    logic [18:0] a_sad, b_sad;

    logic [7:0] mem [2048];
    logic [7:0] b_reg;

    int passed;
    int total;

    fruit_template_sad_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) a_if ();
    fruit_template_sad_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) b_if ();

    fruit_template_sad #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .LENGTH(LEN_A), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .busy(a_busy), .sad(a_sad), .done(a_done), .bus(a_if.master)
    );

    fruit_template_sad #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .LENGTH(LEN_B), .RD_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .busy(b_busy), .sad(b_sad), .done(b_done), .bus(b_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM models: unregistered output (latency 1) and registered output (latency 2).
    always @(posedge clk) a_if.rom_rd_data <= mem[a_if.rom_addr];
    always @(posedge clk) begin
        b_reg <= mem[b_if.rom_addr];
        b_if.rom_rd_data <= b_reg;
    end

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < 2048; i++) mem[i] = ramp ? 8'(i & 255) : 8'hFF;
    endtask

    // One full scan on engine A; start is issued at the next falling edge.
    task automatic run_scan(input string name, input bit ramp, input logic [7:0] fv,
                            input bit gaps, input int exp_sad);
        int n, hs, stalls;
        bit seen, moved, stalled;
        logic [10:0] addr_prev;
        n = 0; hs = 0; stalls = 0; seen = 0; moved = 0; stalled = 0; addr_prev = '0;
        fill_mem(ramp);
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        total++;
        if (a_busy !== 1'b1 || a_if.rom_addr !== 11'd0)
            $display("FAIL %s_start busy=%b addr=%0d required busy=1 addr=0", name, a_busy, a_if.rom_addr);
        else passed++;
        while (n < 20000) begin
            @(negedge clk);
            if (stalled && a_if.rom_addr !== addr_prev) moved = 1;
            a_if.feat_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            a_if.feat_data  = fv;
            stalled   = a_if.feat_ready && !a_if.feat_valid;
            addr_prev = a_if.rom_addr;
            if (stalled) stalls++;
            if (a_if.feat_ready && a_if.feat_valid) hs++;
            @(posedge clk);
            n++;
            #1;
            if (a_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        a_if.feat_valid = 1'b0;
        total++;
        if (!seen) $display("FAIL %s_done no done within %0d cycles, required done", name, n);
        else passed++;
        total++;
        if (a_sad !== 19'(exp_sad)) $display("FAIL %s_sad got %0d required %0d", name, a_sad, exp_sad);
        else passed++;
        total++;
        if (n !== LEN_A * 2 + stalls)
            $display("FAIL %s_latency got %0d edges required %0d", name, n, LEN_A * 2 + stalls);
        else passed++;
        total++;
        if (hs !== LEN_A) $display("FAIL %s_handshakes got %0d required %0d", name, hs, LEN_A);
        else passed++;
        total++;
        if (a_busy !== 1'b0 || a_if.rom_addr !== 11'd0)
            $display("FAIL %s_end busy=%b addr=%0d required busy=0 addr=0", name, a_busy, a_if.rom_addr);
        else passed++;
        if (gaps) begin
            total++;
            if (moved || stalls == 0)
                $display("FAIL %s_stall moved=%0d stalls=%0d required moved=0 stalls>0", name, moved, stalls);
            else passed++;
        end
    endtask

    task automatic test_reset;
        total++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_if.feat_ready !== 1'b0 ||
            a_if.rom_addr !== 11'd0 || a_sad !== 19'd0)
            $display("FAIL reset_a busy=%b done=%b ready=%b addr=%0d sad=%0d required all 0",
                     a_busy, a_done, a_if.feat_ready, a_if.rom_addr, a_sad);
        else passed++;
        total++;
        if (b_busy !== 1'b0 || b_done !== 1'b0 || b_if.feat_ready !== 1'b0 ||
            b_if.rom_addr !== 11'd0 || b_sad !== 19'd0)
            $display("FAIL reset_b busy=%b done=%b ready=%b addr=%0d sad=%0d required all 0",
                     b_busy, b_done, b_if.feat_ready, b_if.rom_addr, b_sad);
        else passed++;
    endtask

    task automatic test_all_match;
        run_scan("match", 1'b0, 8'hFF, 1'b0, 0);
    endtask

    task automatic test_max_diff;
        int extra;
        extra = 0;
        run_scan("maxdiff", 1'b0, 8'h00, 1'b0, 522240);
        repeat (20) begin
            @(posedge clk);
            #1 if (a_done === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL maxdiff_single_done extra pulses %0d required 0", extra);
        else passed++;
    endtask

    task automatic test_abort;
        int hs, n;
        bit aborted, seen_done;
        hs = 0; n = 0; aborted = 0; seen_done = 0;
        fill_mem(1'b1);
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            a_if.feat_valid = 1'b1;
            a_if.feat_data  = 8'h00;
            if (a_if.feat_ready) begin
                if (hs == 100) begin
                    a_abort = 1'b1;
                    aborted = 1;
                    #1;
                    total++;
                    if (a_if.feat_ready !== 1'b0)
                        $display("FAIL abort_ready got %b required 0", a_if.feat_ready);
                    else passed++;
                end else hs++;
            end
            @(posedge clk);
            n++;
            #1;
            if (a_done === 1'b1) seen_done = 1;
            if (aborted) break;
        end
        a_abort = 1'b0;
        a_if.feat_valid = 1'b0;
        total++;
        if (!aborted) $display("FAIL abort_reach sample 100 not reached, hs=%0d required 100", hs);
        else passed++;
        total++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || seen_done || a_if.rom_addr !== 11'd0)
            $display("FAIL abort_state busy=%b done=%b seen_done=%0d addr=%0d required 0 0 0 0",
                     a_busy, a_done, seen_done, a_if.rom_addr);
        else passed++;
        total++;
        if (a_sad !== 19'd522240) $display("FAIL abort_sad_held got %0d required 522240", a_sad);
        else passed++;
        @(negedge clk);
        total++;
        if (a_if.feat_ready !== 1'b0) $display("FAIL abort_idle_ready got %b required 0", a_if.feat_ready);
        else passed++;
        run_scan("restart", 1'b1, 8'h00, 1'b0, 261120);
    endtask

    task automatic test_ramp_gaps;
        run_scan("ramp_gaps", 1'b1, 8'h00, 1'b1, 261120);
    endtask

    task automatic test_reset_midscan;
        fill_mem(1'b0);
        @(negedge clk);
        a_start = 1'b1;
        a_if.feat_valid = 1'b1;
        a_if.feat_data  = 8'h00;
        @(posedge clk);
        #1 a_start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_if.feat_valid = 1'b0;
        total++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_if.feat_ready !== 1'b0 ||
            a_if.rom_addr !== 11'd0 || a_sad !== 19'd0)
            $display("FAIL midscan_reset busy=%b done=%b ready=%b addr=%0d sad=%0d required all 0",
                     a_busy, a_done, a_if.feat_ready, a_if.rom_addr, a_sad);
        else passed++;
        run_scan("post_reset", 1'b1, 8'h00, 1'b0, 261120);
    endtask

    task automatic test_back_to_back;
        run_scan("b2b_first", 1'b0, 8'h00, 1'b0, 522240);
        total++;
        if (a_done !== 1'b1) $display("FAIL b2b_done_cycle done=%b required 1", a_done);
        else passed++;
        run_scan("b2b_second", 1'b1, 8'h00, 1'b0, 261120);
    endtask

    task automatic test_latency2;
        int n, hs, since, early;
        bit seen;
        logic [10:0] last_addr;
        n = 0; hs = 0; since = 0; early = 0; seen = 0;
        fill_mem(1'b1);
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        last_addr = b_if.rom_addr;
        since = -1;
        while (n < 2000) begin
            @(negedge clk);
            if (b_if.rom_addr !== last_addr) since = 0;
            else since++;
            last_addr = b_if.rom_addr;
            if (since < 0) since = 0;
            b_if.feat_valid = 1'b1;
            b_if.feat_data  = 8'h10;
            b_start = (n % 10 == 5);
            if (b_if.feat_ready && since < 2) early++;
            if (b_if.feat_ready) hs++;
            @(posedge clk);
            n++;
            #1;
            if (b_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        b_start = 1'b0;
        b_if.feat_valid = 1'b0;
        total++;
        if (!seen) $display("FAIL lat2_done no done within %0d cycles, required done", n);
        else passed++;
        total++;
        if (b_sad !== 19'd1264) $display("FAIL lat2_sad got %0d required 1264", b_sad);
        else passed++;
        total++;
        if (n !== 3 * LEN_B) $display("FAIL lat2_latency got %0d edges required %0d", n, 3 * LEN_B);
        else passed++;
        total++;
        if (hs !== LEN_B || early !== 0)
            $display("FAIL lat2_ready hs=%0d early=%0d required hs=%0d early=0", hs, early, LEN_B);
        else passed++;
        total++;
        if (b_busy !== 1'b0) $display("FAIL lat2_busy got %b required 0", b_busy);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0;
        b_start = 1'b0; b_abort = 1'b0;
        a_if.feat_valid = 1'b0; a_if.feat_data = '0;
        b_if.feat_valid = 1'b0; b_if.feat_data = '0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_all_match();
        test_max_diff();
        test_abort();
        test_ramp_gaps();
        test_reset_midscan();
        test_back_to_back();
        test_latency2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
